// File: rtl/if_stage.sv
// Instruction fetch: owns the fetch PC, one outstanding imem request, and branch/exception redirects.
// Optional macro IF_ADDR_ERR_EN: misaligned fetches become held if_adel entries instead of memory requests.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PIPELINE_READY,
  output logic        PIPELINE_VALID,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS_4,
  output logic [31:0] IR,
  output logic        if_adel,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_redirect,
  input  logic [31:0] exc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] inflight_pc, inflight_pc_n;
  logic        drop, drop_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] ir_q, ir_n;
  logic        adel_q, adel_n;
  logic        issue;
  logic        misalign;

`ifdef IF_ADDR_ERR_EN
  assign misalign  = |fetch_pc[1:0];
  assign imem_addr = fetch_pc;
  assign if_adel   = adel_q;
`else
  assign misalign  = 1'b0;
  assign imem_addr = {fetch_pc[31:2], 2'b00};
  assign if_adel   = 1'b0;
`endif

  // A fetch slot is consumed in FETCH, or in HOLD when decode takes the held word.
  always_comb begin
    issue = 1'b0;
    case (state)
      S_FETCH: issue = !exc_redirect;
      S_HOLD:  issue = PIPELINE_READY && !exc_redirect;
      default: issue = 1'b0;
    endcase
  end

  assign imem_req       = rst_n && issue && !misalign;
  assign PIPELINE_VALID = (state == S_HOLD);
  assign PC             = pc_q;
  assign PC_PLUS_4      = pc_q + 32'd4;
  assign IR             = ir_q;

  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    inflight_pc_n = inflight_pc;
    drop_n        = drop;
    pc_n          = pc_q;
    ir_n          = ir_q;
    adel_n        = adel_q;

    if (issue) begin
      inflight_pc_n = fetch_pc;
      fetch_pc_n    = fetch_pc + 32'd4;
    end
    // The request issued this cycle still uses the old fetch_pc: that is the delay slot.
    if (exc_redirect)  fetch_pc_n = exc_target;
    else if (br_taken) fetch_pc_n = br_target;

    case (state)
      S_FETCH, S_HOLD: begin
        if (exc_redirect) begin
          ir_n    = 32'h0;
          adel_n  = 1'b0;
          state_n = S_FETCH;
        end else if (issue) begin
          ir_n   = 32'h0;
          adel_n = 1'b0;
          if (misalign) begin
            pc_n    = fetch_pc;
            adel_n  = 1'b1;
            state_n = S_HOLD;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop || exc_redirect) begin
            drop_n  = 1'b0;
            state_n = S_FETCH;
          end else begin
            pc_n    = inflight_pc;
            ir_n    = imem_rdata;
            adel_n  = 1'b0;
            state_n = S_HOLD;
          end
        end else if (exc_redirect) begin
          drop_n = 1'b1;
        end
      end
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      fetch_pc    <= RESET_PC;
      inflight_pc <= RESET_PC;
      drop        <= 1'b0;
      pc_q        <= RESET_PC;
      ir_q        <= 32'h0;
      adel_q      <= 1'b0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      inflight_pc <= inflight_pc_n;
      drop        <= drop_n;
      pc_q        <= pc_n;
      ir_q        <= ir_n;
      adel_q      <= adel_n;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; memory returns ~addr after a programmable latency.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        PIPELINE_READY;
  logic        PIPELINE_VALID;
  logic [31:0] PC, PC_PLUS_4, IR;
  logic        if_adel;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_redirect;
  logic [31:0] exc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int cyc = 0;
  int          due_q[$];
  logic [31:0] addr_q[$];

  if_stage #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .PIPELINE_READY(PIPELINE_READY), .PIPELINE_VALID(PIPELINE_VALID),
    .PC(PC), .PC_PLUS_4(PC_PLUS_4), .IR(IR), .if_adel(if_adel),
    .br_taken(br_taken), .br_target(br_target),
    .exc_redirect(exc_redirect), .exc_target(exc_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: samples requests mid-cycle, answers lat cycles later.
  initial begin
    logic [31:0] a;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (due_q.size() != 0 && due_q[0] == cyc) begin
        a = addr_q.pop_front();
        void'(due_q.pop_front());
        imem_rvalid = 1'b1;
        imem_rdata  = ~a;
      end
      if (imem_req) begin
        due_q.push_back(cyc + lat);
        addr_q.push_back(imem_addr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; PIPELINE_READY = 1'b1;
    br_taken = 1'b0; br_target = 32'h0;
    exc_redirect = 1'b0; exc_target = 32'h0;
    tick(); tick(); #1;
    check("rst_valid", PIPELINE_VALID, 1'b0);
    check("rst_ir", IR, 32'h0);
    check("rst_adel", if_adel, 1'b0);
    check("rst_pc", PC, 32'hBFC0_0000);
    check("rst_pc4", PC_PLUS_4, 32'hBFC0_0004);
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 32'hBFC0_0000);
    rst_n = 1'b1; #1;
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, 32'hBFC0_0000);

    tick(); #1;
    check("wait_valid", PIPELINE_VALID, 1'b0);
    check("wait_req", imem_req, 1'b0);
    tick(); #1;
    check("i0_valid", PIPELINE_VALID, 1'b1);
    check("i0_pc", PC, 32'hBFC0_0000);
    check("i0_ir", IR, 32'h403F_FFFF);
    check("i0_pc4", PC_PLUS_4, 32'hBFC0_0004);
    check("i1_req", imem_req, 1'b1);
    check("i1_addr", imem_addr, 32'hBFC0_0004);
    tick(); PIPELINE_READY = 1'b0; #1;
    check("i1_wait_valid", PIPELINE_VALID, 1'b0);
    check("i1_wait_ir", IR, 32'h0);
    tick(); #1;
    check("i1_valid", PIPELINE_VALID, 1'b1);
    check("i1_pc", PC, 32'hBFC0_0004);
    check("i1_ir", IR, 32'h403F_FFFB);
    check("stall_req", imem_req, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      check("stall_pc", PC, 32'hBFC0_0004);
      check("stall_ir", IR, 32'h403F_FFFB);
      check("stall_req", imem_req, 1'b0);
    end
    tick(); PIPELINE_READY = 1'b1; #1;
    check("release_req", imem_req, 1'b1);
    check("release_addr", imem_addr, 32'hBFC0_0008);
    tick(); PIPELINE_READY = 1'b0; #1;
    check("i2_wait_valid", PIPELINE_VALID, 1'b0);
    tick(); exc_redirect = 1'b1; exc_target = 32'h0000_0100; #1;
    check("i2_pc", PC, 32'hBFC0_0008);
    check("i2_ir", IR, 32'h403F_FFF7);
    check("hold_exc_req", imem_req, 1'b0);
    tick(); exc_redirect = 1'b0; #1;
    check("hold_exc_valid", PIPELINE_VALID, 1'b0);
    check("hold_exc_ir", IR, 32'h0);
    check("redir_req", imem_req, 1'b1);
    check("redir_addr", imem_addr, 32'h0000_0100);

    // Branch at 0x100, delay slot 0x104 in flight while br_taken is held.
    tick();
    tick(); PIPELINE_READY = 1'b1; #1;
    check("br_pc", PC, 32'h0000_0100);
    check("br_ir", IR, 32'hFFFF_FEFF);
    check("ds_addr", imem_addr, 32'h0000_0104);
    tick(); PIPELINE_READY = 1'b0; br_taken = 1'b1; br_target = 32'h0000_0200; #1;
    check("ds_wait_valid", PIPELINE_VALID, 1'b0);
    tick(); #1;
    check("ds_valid", PIPELINE_VALID, 1'b1);
    check("ds_pc", PC, 32'h0000_0104);
    check("ds_ir", IR, 32'hFFFF_FEFB);
    tick();
    tick(); br_taken = 1'b0; PIPELINE_READY = 1'b1; #1;
    check("ds_pc4", PC_PLUS_4, 32'h0000_0108);
    check("tgt_req", imem_req, 1'b1);
    check("tgt_addr", imem_addr, 32'h0000_0200);
    tick(); PIPELINE_READY = 1'b0;
    tick(); lat = 3; PIPELINE_READY = 1'b1; #1;
    check("tgt_pc", PC, 32'h0000_0200);
    check("tgt_ir", IR, 32'hFFFF_FDFF);
    check("seq_addr", imem_addr, 32'h0000_0204);

    // Exception and branch together during WAIT: exception target wins, stale data dropped.
    tick(); PIPELINE_READY = 1'b0; exc_redirect = 1'b1; exc_target = 32'h8000_0180;
    br_taken = 1'b1; br_target = 32'h0000_0300; #1;
    check("exc_wait_req", imem_req, 1'b0);
    tick(); exc_redirect = 1'b0; br_taken = 1'b0; #1;
    check("drop_valid0", PIPELINE_VALID, 1'b0);
    tick(); #1;
    check("drop_valid1", PIPELINE_VALID, 1'b0);
    tick(); #1;
    check("drop_valid2", PIPELINE_VALID, 1'b0);
    check("exc_req", imem_req, 1'b1);
    check("exc_addr", imem_addr, 32'h8000_0180);
    tick(); tick(); tick();
    tick(); PIPELINE_READY = 1'b1; #1;
    check("exc_pc", PC, 32'h8000_0180);
    check("exc_ir", IR, 32'h7FFF_FE7F);
    check("exc_next_addr", imem_addr, 32'h8000_0184);

    // Reset pulse during WAIT; stale response lands in the first cycle after release.
    tick(); PIPELINE_READY = 1'b0; rst_n = 1'b0;
    tick(); #1;
    check("mid_rst_valid", PIPELINE_VALID, 1'b0);
    check("mid_rst_pc", PC, 32'hBFC0_0000);
    check("mid_rst_req", imem_req, 1'b0);
    tick(); rst_n = 1'b1; lat = 1; #1;
    check("post_rst_req", imem_req, 1'b1);
    check("post_rst_addr", imem_addr, 32'hBFC0_0000);
    tick(); #1;
    check("post_rst_wait", PIPELINE_VALID, 1'b0);
    tick(); #1;
    check("post_rst_valid", PIPELINE_VALID, 1'b1);
    check("post_rst_pc", PC, 32'hBFC0_0000);
    check("post_rst_ir", IR, 32'h403F_FFFF);

    tick(); exc_redirect = 1'b1; exc_target = 32'h8000_0182; #1;
    check("mis_exc_req", imem_req, 1'b0);
    tick(); exc_redirect = 1'b0; #1;
`ifdef IF_ADDR_ERR_EN
    check("adel_req", imem_req, 1'b0);
    tick(); #1;
    check("adel_valid", PIPELINE_VALID, 1'b1);
    check("adel_ir", IR, 32'h0);
    check("adel_flag", if_adel, 1'b1);
    check("adel_pc", PC, 32'h8000_0182);
`else
    check("mis_req", imem_req, 1'b1);
    check("mis_addr", imem_addr, 32'h8000_0180);
    tick(); tick(); #1;
    check("mis_valid", PIPELINE_VALID, 1'b1);
    check("mis_adel", if_adel, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
